program_loader: RTL and testbench

Upstream stage of the micro-computer: loads a 16-word × 8-bit program image into the CPU's RAM through its write port while holding the CPU in reset, then releases it. Bytes arrive on a valid/ready byte stream and are followed by one checksum byte. If the checksum fails, the CPU stays held and an error is flagged.

---
 rtl/program_loader.sv | 171 +++++++++++++++++
 tb/tb_program_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Loads a DEPTH-word program image into the CPU's RAM through its write port
// while the CPU is held, then checks one trailing checksum byte. A good image
// releases the CPU (done=1, cpu_hold=0); a bad one keeps it held and raises
// chk_err. A start pulse in any state begins a fresh load.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset
//   start       single-cycle request to begin or restart a load
//   in_valid    in_data holds a byte
//   in_data     image byte or checksum byte
//   in_ready    loader accepts a byte this cycle (decoded from state, start)
//   mem_we      one-cycle RAM write strobe
//   mem_addr    RAM write address
//   mem_wdata   RAM write data
//   cpu_hold    1 = CPU held
//   busy        load or checksum phase in progress
//   done        image loaded and checksum good (level)
//   chk_err     checksum mismatch (level)
//   word_count  image bytes written so far, 0..DEPTH
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              chk_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    // Count value of the last image byte; accepting it moves us to CHECK.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    logic [2:0]        state_reg,      state_next;
    logic [DATA_W-1:0] sum_reg,        sum_next;
    logic [ADDR_W:0]   word_count_reg, word_count_next;
    logic              mem_we_reg,     mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg,   mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg,  mem_wdata_next;
    logic              cpu_hold_reg,   cpu_hold_next;
    logic              busy_reg,       busy_next;
    logic              done_reg,       done_next;
    logic              chk_err_reg,    chk_err_next;

    logic              accept;
    logic [DATA_W-1:0] sum_plus;

    // start has priority over a byte: dropping ready in the start cycle
    // guarantees the byte presented alongside start is never consumed.
    assign in_ready = ((state_reg == ST_LOAD) || (state_reg == ST_CHECK)) && !start;
    assign accept   = in_valid && in_ready;

    // Running modulo-2^DATA_W sum including the byte on the bus this cycle.
    // In CHECK this is sum+checksum, which must wrap to zero for a good image.
    assign sum_plus = sum_reg + in_data;

    always_comb begin
        state_next      = state_reg;
        sum_next        = sum_reg;
        word_count_next = word_count_reg;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;

        if (start) begin
            state_next      = ST_LOAD;
            sum_next        = '0;
            word_count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_LOAD: begin
                    if (accept) begin
                        mem_we_next     = 1'b1;
                        mem_addr_next   = word_count_reg[ADDR_W-1:0];
                        mem_wdata_next  = in_data;
                        sum_next        = sum_plus;
                        word_count_next = word_count_reg + 1'b1;
                        if (word_count_reg == LAST_CNT) begin
                            state_next = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // The checksum byte is consumed but never written to RAM.
                    if (accept) begin
                        state_next = (sum_plus == '0) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                ST_ERROR: begin
                    state_next = ST_ERROR;
                end
                default: begin
                    // Unused encodings fall back to a safe, held state.
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Status outputs are registered from the next state so they line up
        // with the state register itself (e.g. done appears the cycle after
        // the checksum accept, busy the cycle after start).
        busy_next     = (state_next == ST_LOAD) || (state_next == ST_CHECK);
        done_next     = (state_next == ST_DONE);
        chk_err_next  = (state_next == ST_ERROR);
        cpu_hold_next = (state_next != ST_DONE);
    end

    // Reset drops any write strobe in flight and re-holds the CPU at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            sum_reg        <= '0;
            word_count_reg <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_hold_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            chk_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sum_reg        <= sum_next;
            word_count_reg <= word_count_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            cpu_hold_reg   <= cpu_hold_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            chk_err_reg    <= chk_err_next;
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign chk_err    = chk_err_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. A behavioural model tracks the
// loader's phase, running sum, byte count and the expected RAM image; a
// negedge process compares every DUT output against it each cycle and keeps
// a shadow copy of the RAM from the DUT's write strobes. Directed scenarios
// add literal expectations, followed by randomized images, stalls, restarts
// and bad checksums.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              chk_err;
    logic [ADDR_W:0]   word_count;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .chk_err    (chk_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for start, 1 taking image bytes, 2 awaiting checksum,
    //        3 image good, 4 image bad
    int m_phase = 0;
    int m_sum   = 0;
    int m_count = 0;
    bit m_we    = 0;
    int m_addr  = 0;
    int m_data  = 0;
    int model_ram [DEPTH];
    int dut_ram   [DEPTH];
    int we_pulses = 0;
    bit chk_en    = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_sum   = 0;
            m_count = 0;
            m_we    = 0;
            m_addr  = 0;
            m_data  = 0;
        end else begin
            bit took;
            took = (m_phase == 1 || m_phase == 2) && !start && in_valid;
            m_we = took && (m_phase == 1);
            if (m_we) begin
                m_addr = m_count % DEPTH;
                m_data = int'(in_data);
                model_ram[m_addr] = m_data;
            end
            if (start) begin
                m_phase = 1;
                m_sum   = 0;
                m_count = 0;
            end else if (took) begin
                if (m_phase == 1) begin
                    m_sum   = (m_sum + int'(in_data)) % 256;
                    m_count = m_count + 1;
                    if (m_count == DEPTH) m_phase = 2;
                end else begin
                    m_phase = ((m_sum + int'(in_data)) % 256 == 0) ? 3 : 4;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   in_ready,   ((m_phase == 1 || m_phase == 2) && !start) ? 1 : 0);
            chk("mem_we",     mem_we,     m_we);
            chk("mem_addr",   mem_addr,   m_addr);
            chk("mem_wdata",  mem_wdata,  m_data);
            chk("word_count", word_count, m_count);
            chk("busy",       busy,       (m_phase == 1 || m_phase == 2) ? 1 : 0);
            chk("done",       done,       (m_phase == 3) ? 1 : 0);
            chk("chk_err",    chk_err,    (m_phase == 4) ? 1 : 0);
            chk("cpu_hold",   cpu_hold,   (m_phase != 3) ? 1 : 0);
            if (mem_we === 1'b1) begin
                dut_ram[mem_addr] = int'(mem_wdata);
                we_pulses++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_valid);
        start    = 1'b1;
        in_valid = with_valid;
        in_data  = DATA_W'($urandom);
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic put(input logic [DATA_W-1:0] d, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        repeat (gap) cyc();
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            chk(tag, dut_ram[a], model_ram[a]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            model_ram[a] = 0;
            dut_ram[a]   = 0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset then idle: nothing happens without start.
        we_pulses = 0;
        repeat (5) cyc();
        chk("idle_hold",   cpu_hold, 1);
        chk("idle_ready",  in_ready, 0);
        chk("idle_count",  word_count, 0);
        chk("idle_writes", we_pulses, 0);

        // Good load 0x00..0x0F, checksum 0x88.
        we_pulses = 0;
        do_start(0);
        for (int i = 0; i < DEPTH; i++) put(DATA_W'(i), 0);
        put(8'h88, 0);
        chk("good_done",   done, 1);
        chk("good_hold",   cpu_hold, 0);
        chk("good_writes", we_pulses, 16);
        for (int a = 0; a < DEPTH; a++) chk("good_ram", dut_ram[a], a);

        // Bad checksum 0x87, then a good reload.
        do_start(0);
        for (int i = 0; i < DEPTH; i++) put(DATA_W'(i), 0);
        put(8'h87, 0);
        chk("bad_err",  chk_err, 1);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_done", done, 0);
        do_start(0);
        for (int i = 0; i < DEPTH; i++) put(DATA_W'(i), 0);
        put(8'h88, 0);
        chk("reload_done", done, 1);
        chk("reload_err",  chk_err, 0);

        // Stalls: 3 idle cycles between bytes.
        we_pulses = 0;
        do_start(0);
        for (int i = 0; i < DEPTH; i++) put(DATA_W'(i), 3);
        put(8'h88, 3);
        chk("stall_done",   done, 1);
        chk("stall_writes", we_pulses, 16);
        for (int a = 0; a < DEPTH; a++) chk("stall_ram", dut_ram[a], a);

        // Restart mid-load with a byte presented alongside start.
        do_start(0);
        for (int i = 0; i < 5; i++) put(8'hAA, 0);
        do_start(1);
        chk("restart_count", word_count, 0);
        chk("restart_busy",  busy, 1);
        for (int i = 0; i < DEPTH; i++) put(8'h11, 0);
        put(8'hF0, 0);
        chk("restart_done", done, 1);
        for (int a = 0; a < DEPTH; a++) chk("restart_ram", dut_ram[a], 8'h11);

        // Async reset after 8 bytes.
        do_start(0);
        for (int i = 0; i < 8; i++) put(8'h5A, 0);
        reset_n = 1'b0;
        #1;
        chk("arst_busy",  busy, 0);
        chk("arst_count", word_count, 0);
        chk("arst_hold",  cpu_hold, 1);
        chk("arst_ready", in_ready, 0);
        chk("arst_we",    mem_we, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) put(8'h33, 0);
        chk("arst_ignored", word_count, 0);

        // Randomized images with stalls, restarts and corrupted checksums.
        for (int it = 0; it < 40; it++) begin
            int  sum;
            int  restart_at;
            int  idx;
            bit  good;
            logic [DATA_W-1:0] b;
            logic [DATA_W-1:0] ck;
            do_start($urandom_range(0, 1) == 1);
            sum        = 0;
            restart_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
            idx        = 0;
            while (idx < DEPTH) begin
                if (idx == restart_at) begin
                    do_start($urandom_range(0, 1) == 1);
                    restart_at = -1;
                    idx        = 0;
                    sum        = 0;
                end
                b = DATA_W'($urandom);
                put(b, $urandom_range(0, 2));
                sum = sum + int'(b);
                idx++;
            end
            good = ($urandom_range(0, 3) != 0);
            ck   = DATA_W'((256 - (sum % 256)) % 256);
            if (!good) ck = ck + DATA_W'($urandom_range(1, 255));
            put(ck, $urandom_range(0, 3));
            chk("rand_done", done, good);
            chk("rand_err",  chk_err, !good);
            put(DATA_W'($urandom), 1);
            check_ram("rand_ram");
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard bound on run time in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
